// File: rtl/connection_mgr_pkg.sv
// Shared state encoding, status codes and helpers for the connection manager.
// Host address width comes from HOST_ADDR_WIDTH; it defaults to 32 when that macro is not defined.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 32
`endif

package connection_mgr_pkg;

    localparam int HOST_ADDR_W = `HOST_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_BACKOFF   = 3'd3,
        ST_CONNECTED = 3'd4
    } conn_state_e;

    localparam logic STATUS_REJECT = 1'b0;
    localparam logic STATUS_OK     = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/connection_mgr_timer.sv
// Load/decrement down counter with a zero flag.
// One instance is shared between the attempt timeout and the retry backoff.
module connection_mgr_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // The counter holds at zero instead of wrapping, so a late dec cannot re-arm it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/connection_mgr.sv
// Session connect sequencer: one connect request at a time, with timeout, retry and backoff toward the TOE.
// Defining CONN_MGR_STATS_EN adds the saturating attempt and failure counters attempt_cnt_o and fail_cnt_o.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | ready for a request (req_ready_o high)
// ST_ISSUE     | connect_o pulse for one cycle, timeout armed
// ST_WAIT      | waiting for a TOE status that matches the latched address
// ST_BACKOFF   | idle gap after a failed attempt, before the retry
// ST_CONNECTED | session up until disconnect_i
module connection_mgr
    import connection_mgr_pkg::*;
#(
    parameter int HOST_ADDR   = HOST_ADDR_W,
    parameter int TIMEOUT_CYC = 1024,
    parameter int BACKOFF_CYC = 256,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    input  logic [HOST_ADDR-1:0] req_addr_i,
    output logic                 req_ready_o,
    input  logic                 disconnect_i,
    output logic                 connect_o,
    output logic [HOST_ADDR-1:0] connect_addr_o,
    input  logic                 status_valid_i,
    input  logic                 status_ok_i,
    input  logic [HOST_ADDR-1:0] status_addr_i,
    output logic                 connected_o,
    output logic                 fail_o
`ifdef CONN_MGR_STATS_EN
    ,
    output logic [15:0]          attempt_cnt_o,
    output logic [15:0]          fail_cnt_o
`endif
);

    localparam int TMR_W = max_int($clog2(max_int(TIMEOUT_CYC, BACKOFF_CYC)), 1);
    localparam int RTY_W = max_int($clog2(MAX_RETRY + 1), 1);

    conn_state_e      state;
    logic [RTY_W-1:0] retry_cnt;

    logic             status_hit;
    logic             fail_path;
    logic             tmr_zero;
    logic             tmr_load;
    logic             tmr_dec;
    logic [TMR_W-1:0] tmr_load_val;

    // Matching status beats an expiring timer in the same cycle.
    assign status_hit = status_valid_i && (status_addr_i == connect_addr_o);
    assign fail_path  = (state == ST_WAIT) && !disconnect_i &&
                        (status_hit ? (status_ok_i == STATUS_REJECT) : tmr_zero);

    assign tmr_load     = (state == ST_ISSUE) || fail_path;
    assign tmr_load_val = (state == ST_ISSUE) ? TMR_W'(TIMEOUT_CYC - 1) : TMR_W'(BACKOFF_CYC - 1);
    assign tmr_dec      = (state == ST_WAIT) || (state == ST_BACKOFF);

    connection_mgr_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            retry_cnt      <= '0;
            req_ready_o    <= 1'b1;
            connect_o      <= 1'b0;
            connect_addr_o <= '0;
            connected_o    <= 1'b0;
            fail_o         <= 1'b0;
        end else begin
            connect_o <= 1'b0;
            fail_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        connect_addr_o <= req_addr_i;
                        retry_cnt      <= '0;
                        connect_o      <= 1'b1;
                        req_ready_o    <= 1'b0;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (disconnect_i) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (disconnect_i) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                    end else if (status_hit && (status_ok_i == STATUS_OK)) begin
                        state       <= ST_CONNECTED;
                        connected_o <= 1'b1;
                    end else if (fail_path) begin
                        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RTY_W'(1);
                            state     <= ST_BACKOFF;
                        end else begin
                            fail_o      <= 1'b1;
                            req_ready_o <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (disconnect_i) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                    end else if (tmr_zero) begin
                        connect_o <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_CONNECTED: begin
                    if (disconnect_i) begin
                        connected_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    connected_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONN_MGR_STATS_EN
    // Counting the registered pulses, so each count follows its pulse by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            attempt_cnt_o <= '0;
            fail_cnt_o    <= '0;
        end else begin
            if (connect_o && (attempt_cnt_o != 16'hFFFF)) begin
                attempt_cnt_o <= attempt_cnt_o + 16'd1;
            end
            if (fail_o && (fail_cnt_o != 16'hFFFF)) begin
                fail_cnt_o <= fail_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_connection_mgr.sv
// Directed bench for connection_mgr with short timeout/backoff, hand-computed expectations.
// Also builds with CONN_MGR_STATS_EN defined, which connects and checks the counter ports.
module tb_connection_mgr;

    localparam int AW  = 32;
    localparam int TO  = 16;
    localparam int BO  = 4;
    localparam int MR  = 2;
    localparam int GAP = TO + BO + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready_o;
    logic          disconnect = 1'b0;
    logic          connect_o;
    logic [AW-1:0] connect_addr_o;
    logic          status_valid = 1'b0;
    logic          status_ok = 1'b0;
    logic [AW-1:0] status_addr = '0;
    logic          connected_o;
    logic          fail_o;
`ifdef CONN_MGR_STATS_EN
    logic [15:0]   attempt_cnt_o;
    logic [15:0]   fail_cnt_o;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_conn = 0;
    int n_fail = 0;
    int fail_cyc = 0;
    int conn_cyc[$];

    connection_mgr #(
        .HOST_ADDR   (AW),
        .TIMEOUT_CYC (TO),
        .BACKOFF_CYC (BO),
        .MAX_RETRY   (MR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_ready_o    (req_ready_o),
        .disconnect_i   (disconnect),
        .connect_o      (connect_o),
        .connect_addr_o (connect_addr_o),
        .status_valid_i (status_valid),
        .status_ok_i    (status_ok),
        .status_addr_i  (status_addr),
        .connected_o    (connected_o),
        .fail_o         (fail_o)
`ifdef CONN_MGR_STATS_EN
        ,
        .attempt_cnt_o  (attempt_cnt_o),
        .fail_cnt_o     (fail_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (connect_o === 1'b1) begin
            n_conn++;
            conn_cyc.push_back(cyc);
        end
        if (fail_o === 1'b1) begin
            n_fail++;
            fail_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_conn = 0;
        n_fail = 0;
        conn_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_chk++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
        n_chk++; if (connect_o !== 1'b0) begin n_bad++; $display("FAIL reset_connect got=%b want=0", connect_o); end
        n_chk++; if (connected_o !== 1'b0) begin n_bad++; $display("FAIL reset_connected got=%b want=0", connected_o); end
        n_chk++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL reset_fail got=%b want=0", fail_o); end
        n_chk++; if (connect_addr_o !== '0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", connect_addr_o); end
`ifdef CONN_MGR_STATS_EN
        n_chk++; if (attempt_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_attempt_cnt got=%0d want=0", attempt_cnt_o); end
`endif
        rst = 1'b1;
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
        n_chk++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL idle_disconnect_ready got=%b want=1", req_ready_o); end
    endtask

    task automatic test_happy();
        clear_mon();
        req_addr  = 32'h0A000001;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_chk++; if (connect_o !== 1'b1) begin n_bad++; $display("FAIL happy_connect got=%b want=1", connect_o); end
        n_chk++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL happy_ready_busy got=%b want=0", req_ready_o); end
        n_chk++; if (connect_addr_o !== 32'h0A000001) begin n_bad++; $display("FAIL happy_addr got=%h want=0a000001", connect_addr_o); end
        tick();
        n_chk++; if (connect_o !== 1'b0) begin n_bad++; $display("FAIL happy_pulse_width got=%b want=0", connect_o); end
        repeat (3) tick();
        status_valid = 1'b1;
        status_ok    = 1'b1;
        status_addr  = 32'h0A000001;
        tick();
        status_valid = 1'b0;
        n_chk++; if (connected_o !== 1'b1) begin n_bad++; $display("FAIL happy_connected got=%b want=1", connected_o); end
        repeat (3) tick();
        n_chk++; if (connected_o !== 1'b1) begin n_bad++; $display("FAIL happy_hold got=%b want=1", connected_o); end
        n_chk++; if (connect_addr_o !== 32'h0A000001) begin n_bad++; $display("FAIL happy_addr_stable got=%h want=0a000001", connect_addr_o); end
        n_chk++; if (n_conn !== 1) begin n_bad++; $display("FAIL happy_conn_count got=%0d want=1", n_conn); end
        n_chk++; if (n_fail !== 0) begin n_bad++; $display("FAIL happy_no_fail got=%0d want=0", n_fail); end
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
        n_chk++; if (connected_o !== 1'b0) begin n_bad++; $display("FAIL happy_disconnect got=%b want=0", connected_o); end
        n_chk++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL happy_ready_back got=%b want=1", req_ready_o); end
    endtask

    task automatic test_timeout();
        clear_mon();
        req_addr  = 32'h0A000003;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 200 && n_fail == 0; i++) tick();
        n_chk++; if (n_fail !== 1) begin n_bad++; $display("FAIL timeout_fail_seen got=%0d want=1", n_fail); end
        n_chk++; if (fail_o !== 1'b1 || req_ready_o !== 1'b1) begin n_bad++; $display("FAIL timeout_fail_idle got=%b%b want=11", fail_o, req_ready_o); end
        n_chk++; if (n_conn !== MR + 1) begin n_bad++; $display("FAIL timeout_attempts got=%0d want=%0d", n_conn, MR + 1); end
        n_chk++;
        if (conn_cyc.size() < 3 || conn_cyc[1] - conn_cyc[0] != GAP || conn_cyc[2] - conn_cyc[1] != GAP) begin
            n_bad++;
            $display("FAIL timeout_spacing got=%0d,%0d want=%0d", (conn_cyc.size() > 1) ? conn_cyc[1] - conn_cyc[0] : -1,
                     (conn_cyc.size() > 2) ? conn_cyc[2] - conn_cyc[1] : -1, GAP);
        end
        n_chk++;
        if (conn_cyc.size() < 3 || fail_cyc - conn_cyc[2] != TO + 1) begin
            n_bad++;
            $display("FAIL timeout_fail_time got=%0d want=%0d", (conn_cyc.size() > 2) ? fail_cyc - conn_cyc[2] : -1, TO + 1);
        end
        tick();
        n_chk++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL timeout_fail_pulse got=%b want=0", fail_o); end
        repeat (GAP) tick();
        n_chk++; if (n_conn !== MR + 1 || n_fail !== 1) begin n_bad++; $display("FAIL timeout_quiet got=%0d/%0d want=%0d/1", n_conn, n_fail, MR + 1); end
    endtask

    task automatic test_reject_accept();
        clear_mon();
        req_addr  = 32'h0A000004;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        status_valid = 1'b1;
        status_ok    = 1'b0;
        status_addr  = 32'h0A000004;
        tick();
        status_valid = 1'b0;
        n_chk++; if (connected_o !== 1'b0) begin n_bad++; $display("FAIL reject_not_connected got=%b want=0", connected_o); end
        for (int i = 0; i < 50 && n_conn < 2; i++) tick();
        n_chk++; if (connect_o !== 1'b1) begin n_bad++; $display("FAIL reject_retry_pulse got=%b want=1", connect_o); end
        tick();
        status_valid = 1'b1;
        status_ok    = 1'b1;
        tick();
        status_valid = 1'b0;
        n_chk++; if (connected_o !== 1'b1) begin n_bad++; $display("FAIL reject_then_ok got=%b want=1", connected_o); end
        n_chk++; if (n_conn !== 2 || n_fail !== 0) begin n_bad++; $display("FAIL reject_counts got=%0d/%0d want=2/0", n_conn, n_fail); end
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
    endtask

    task automatic test_addr_mismatch();
        clear_mon();
        req_addr  = 32'h0A000001;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        status_valid = 1'b1;
        status_ok    = 1'b1;
        status_addr  = 32'h0A000002;
        tick();
        status_valid = 1'b0;
        n_chk++; if (connected_o !== 1'b0) begin n_bad++; $display("FAIL mismatch_ignored got=%b want=0", connected_o); end
        for (int i = 0; i < 50 && n_conn < 2; i++) tick();
        n_chk++;
        if (conn_cyc.size() < 2 || conn_cyc[1] - conn_cyc[0] != GAP) begin
            n_bad++;
            $display("FAIL mismatch_retry_gap got=%0d want=%0d", (conn_cyc.size() > 1) ? conn_cyc[1] - conn_cyc[0] : -1, GAP);
        end
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
        n_chk++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL mismatch_abort_ready got=%b want=1", req_ready_o); end
    endtask

    task automatic test_race();
        clear_mon();
        req_addr  = 32'h0A000005;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (TO) tick();
        status_valid = 1'b1;
        status_ok    = 1'b1;
        status_addr  = 32'h0A000005;
        tick();
        status_valid = 1'b0;
        n_chk++; if (connected_o !== 1'b1) begin n_bad++; $display("FAIL race_status_wins got=%b want=1", connected_o); end
        repeat (BO + 2) tick();
        n_chk++; if (n_conn !== 1) begin n_bad++; $display("FAIL race_no_retry got=%0d want=1", n_conn); end
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
    endtask

    task automatic test_abort_backoff();
        clear_mon();
        req_addr  = 32'h0A000006;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (TO + 2) tick();
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
        n_chk++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b want=1", req_ready_o); end
        repeat (GAP + 2) tick();
        n_chk++; if (n_fail !== 0 || n_conn !== 1) begin n_bad++; $display("FAIL abort_quiet got=%0d/%0d want=0/1", n_fail, n_conn); end
    endtask

    task automatic test_reset_in_wait();
        clear_mon();
        req_addr  = 32'h0A000007;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_chk++; if (req_ready_o !== 1'b1 || connect_o !== 1'b0 || fail_o !== 1'b0 || connected_o !== 1'b0) begin
            n_bad++; $display("FAIL rstwait_outputs got=%b%b%b%b want=1000", req_ready_o, connect_o, fail_o, connected_o);
        end
        n_chk++; if (connect_addr_o !== '0) begin n_bad++; $display("FAIL rstwait_addr got=%h want=0", connect_addr_o); end
`ifdef CONN_MGR_STATS_EN
        n_chk++; if (attempt_cnt_o !== 16'd0 || fail_cnt_o !== 16'd0) begin
            n_bad++; $display("FAIL rstwait_stats got=%0d/%0d want=0/0", attempt_cnt_o, fail_cnt_o);
        end
`endif
        tick();
        n_chk++; if (connect_o !== 1'b0 || fail_o !== 1'b0) begin n_bad++; $display("FAIL rstwait_after got=%b%b want=00", connect_o, fail_o); end
        repeat (TO + BO) tick();
        n_chk++; if (n_conn !== 1 || n_fail !== 0) begin n_bad++; $display("FAIL rstwait_quiet got=%0d/%0d want=1/0", n_conn, n_fail); end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_timeout();
        test_reject_accept();
        test_addr_mismatch();
        test_race();
        test_abort_backoff();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
